mul_seq_ctrl: RTL

//  Sequencer for the multi-cycle mul (opcode 6'h1c, funct 6'h02) in the EX stage.

---
 rtl/mul_pkg.sv | 22 ++
 rtl/mul_pp_step.sv | 46 ++++
 rtl/mul_seq_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mul_pkg (package)
//  Description : Shared types and constants for the multi-cycle mul
//                sequencer: FSM state encoding and the instruction fields
//                that identify the mul instruction in decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mul_state_t;

    localparam logic [5:0] MUL_OPCODE = 6'h1c;
    localparam logic [5:0] MUL_FUNCT  = 6'h02;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_pp_step.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mul_pp_step
//  Description : Combinational single step of the shift-add multiplier.
//                Adds the partial product a_r * b_r[BITS_PER_CYCLE-1:0] to
//                the accumulator (truncated to WIDTH) and shifts the operands
//                ready for the next step.
//  Ports       : acc, a_r, b_r           - current accumulator / operands
//                acc_next, a_next, b_next - values after one step
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_pp_step
    import mul_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a_r,
    input  logic [WIDTH-1:0] b_r,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] b_next
);

    logic [WIDTH-1:0] pp;

    // Partial product built from shifted copies of the multiplicand, one per
    // multiplier bit retired this step; bits shifted past WIDTH are dropped
    // since only the low product is kept.
    always_comb begin
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (b_r[i]) begin
                pp = pp + (a_r << i);
            end
        end
    end

    assign acc_next = acc + pp;
    assign a_next   = a_r << BITS_PER_CYCLE;
    assign b_next   = b_r >> BITS_PER_CYCLE;

endmodule : mul_pp_step
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mul_seq_ctrl
//  Description : EX-stage sequencer for the multi-cycle mul instruction.
//                Runs an iterative unsigned shift-add multiplier and stalls
//                the pipeline until the low WIDTH bits of the product are
//                ready. Optional early termination is enabled by defining
//                the macro MUL_EARLY_TERM_EN.
//  Ports       : clk          - system clock
//                reset        - synchronous, active-low reset
//                start        - mul instruction present in EX
//                op_a, op_b   - multiplicand / multiplier (after forwarding)
//                flush        - abort current operation
//                stall        - freeze PC, IF/ID and ID/EX
//                busy         - sequencer not idle
//                result       - low WIDTH bits of op_a*op_b, held
//                result_valid - one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    mul_state_t       state, state_next;
    logic [WIDTH-1:0] acc, a_r, b_r;
    logic [WIDTH-1:0] acc_nx, a_nx, b_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] result_r;
    logic             valid_r;
    logic             last_step;

    mul_pp_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc      (acc),
        .a_r      (a_r),
        .b_r      (b_r),
        .acc_next (acc_nx),
        .a_next   (a_nx),
        .b_next   (b_nx)
    );

`ifdef MUL_EARLY_TERM_EN
    // Once the remaining multiplier bits are all zero no further partial
    // products can contribute, so this step is the last one.
    assign last_step = (cnt == CNT_LAST) || (b_nx == '0);
`else
    assign last_step = (cnt == CNT_LAST);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and stall
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = start & ~flush;
                if (start && !flush) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall = ~flush;
                if (flush) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Stall drops here so the pipeline advances on this edge.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath, counter and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            cnt      <= '0;
            result_r <= '0;
            valid_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        acc <= '0;
                        a_r <= op_a;
                        b_r <= op_b;
                        cnt <= '0;
                    end
                end
                BUSY: begin
                    if (!flush) begin
                        acc <= acc_nx;
                        a_r <= a_nx;
                        b_r <= b_nx;
                        cnt <= cnt + CNT_W'(1);
                        // Capture the final product on entry to DONE so it is
                        // visible during the completion cycle.
                        if (last_step) begin
                            result_r <= acc_nx;
                            valid_r  <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign result       = result_r;
    // A flush arriving in the completion cycle still suppresses the pulse.
    assign result_valid = valid_r & ~flush;

endmodule : mul_seq_ctrl
`default_nettype wire
